// File: rtl/wb_stage.sv
// wb_stage: write-back stage driving the register-bank write port; define WB_LOAD_TIMEOUT_EN for the load-response timeout.
module wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_rd_we_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_result_i,
  input  logic        ex_is_load_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [1:0]  ex_addr_lsb_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_addr_o,
  output logic [31:0] rf_rd_data_o,
  output logic        retire_o,
  output logic        load_err_o
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t      state;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lsb_q;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ld;
  logic        fault;
`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
`endif
  assign ex_ready_o = state == IDLE;
  always_comb begin
    b = dmem_rdata_i[{lsb_q, 3'b000} +: 8];
    h = lsb_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    ld = f3_q == 3'b000 ? {{24{b[7]}}, b} :
         f3_q == 3'b001 ? {{16{h[15]}}, h} :
         f3_q == 3'b100 ? {24'b0, b} :
         f3_q == 3'b101 ? {16'b0, h} : dmem_rdata_i;
    fault = dmem_err_i | (f3_q[1:0] == 2'b01 & lsb_q[0]) | (f3_q == 3'b010 & lsb_q != 2'b00) |
            f3_q == 3'b011 | f3_q[2:1] == 2'b11;
  end
  always_ff @(posedge clk) begin
    rf_we_o <= 1'b0;
    rf_rd_addr_o <= '0;
    rf_rd_data_o <= '0;
    retire_o <= 1'b0;
    load_err_o <= 1'b0;
    if (rst) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (ex_valid_i && ex_is_load_i) begin
        state <= WAIT_LOAD;
        rd_q <= ex_rd_addr_i;
        we_q <= ex_rd_we_i;
        f3_q <= ex_funct3_i;
        lsb_q <= ex_addr_lsb_i;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt <= '0;
`endif
      end else if (ex_valid_i) begin
        retire_o <= 1'b1;
        rf_rd_addr_o <= ex_rd_addr_i;
        rf_rd_data_o <= ex_result_i;
        rf_we_o <= ex_rd_we_i && ex_rd_addr_i != 5'd0;
      end
    end else if (dmem_rvalid_i) begin
      state <= IDLE;
      retire_o <= 1'b1;
      load_err_o <= fault;
      rf_rd_addr_o <= rd_q;
      rf_rd_data_o <= ld;
      rf_we_o <= !fault && we_q && rd_q != 5'd0;
`ifdef WB_LOAD_TIMEOUT_EN
    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      state <= IDLE;
      retire_o <= 1'b1;
      load_err_o <= 1'b1;
      rf_rd_addr_o <= rd_q;
    end else begin
      cnt <= cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a cycle model and literal spot checks.
module tb_wb_stage;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic ex_valid_i = 0, ex_rd_we_i = 0, ex_is_load_i = 0, dmem_rvalid_i = 0, dmem_err_i = 0;
  logic [4:0] ex_rd_addr_i = 0;
  logic [31:0] ex_result_i = 0, dmem_rdata_i = 0;
  logic [2:0] ex_funct3_i = 0;
  logic [1:0] ex_addr_lsb_i = 0;
  logic ex_ready_o, rf_we_o, retire_o, load_err_o;
  logic [4:0] rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;
  int tests = 0, fails = 0;

  wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rd_we_i(ex_rd_we_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_result_i(ex_result_i),
    .ex_is_load_i(ex_is_load_i), .ex_funct3_i(ex_funct3_i), .ex_addr_lsb_i(ex_addr_lsb_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i),
    .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
    .retire_o(retire_o), .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] d, input int f3, input int lsb, output bit bad);
    logic [31:0] v;
    bad = 0;
    v = d;
    case (f3)
      0, 4: begin
        v = (d >> (8 * lsb)) & 32'hFF;
        if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      1, 5: begin
        bad = (lsb % 2) != 0;
        v = (d >> (16 * (lsb / 2))) & 32'hFFFF;
        if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      2: bad = lsb != 0;
      default: bad = 1;
    endcase
    return v;
  endfunction

  bit busy = 0;
  bit m_we;
  int m_rd, m_f3, m_lsb, waited;
  bit e_we, e_ret, e_err;
  int e_addr;
  logic [31:0] e_data;
  always @(posedge clk) begin
    bit bad;
    e_we = 0; e_ret = 0; e_err = 0; e_addr = 0; e_data = 0;
    if (rst) busy = 0;
    else if (!busy) begin
      if (ex_valid_i && ex_is_load_i) begin
        busy = 1; m_we = ex_rd_we_i; m_rd = ex_rd_addr_i; m_f3 = ex_funct3_i; m_lsb = ex_addr_lsb_i; waited = 0;
      end else if (ex_valid_i) begin
        e_ret = 1; e_addr = ex_rd_addr_i; e_data = ex_result_i; e_we = ex_rd_we_i && ex_rd_addr_i != 0;
      end
    end else if (dmem_rvalid_i) begin
      busy = 0;
      e_data = load_value(dmem_rdata_i, m_f3, m_lsb, bad);
      e_ret = 1; e_addr = m_rd; e_err = bad || dmem_err_i;
      e_we = !e_err && m_we && m_rd != 0;
    end else begin
      waited++;
`ifdef WB_LOAD_TIMEOUT_EN
      if (waited == TO) begin
        busy = 0; e_ret = 1; e_err = 1; e_addr = m_rd;
      end
`endif
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_ready", ex_ready_o, !busy);
      chk("m_retire", retire_o, e_ret);
      chk("m_we", rf_we_o, e_we);
      chk("m_err", load_err_o, e_err);
      if (e_ret) chk("m_addr", rf_rd_addr_o, e_addr);
      if (e_ret && !e_err) chk("m_data", rf_rd_data_o, e_data);
    end
  end

  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] d,
                         input bit err, input int dly, input logic [31:0] exp_d, input bit exp_we, input bit exp_err);
    ex_valid_i = 1; ex_is_load_i = 1; ex_rd_we_i = 1; ex_rd_addr_i = 7; ex_funct3_i = f3; ex_addr_lsb_i = lsb;
    tick;
    ex_valid_i = 0; ex_is_load_i = 0;
    repeat (dly) tick;
    chk({name, "_wait_ready"}, ex_ready_o, 0);
    chk({name, "_wait_retire"}, retire_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = d; dmem_err_i = err;
    tick;
    dmem_rvalid_i = 0; dmem_err_i = 0;
    chk({name, "_retire"}, retire_o, 1);
    chk({name, "_we"}, rf_we_o, exp_we);
    chk({name, "_err"}, load_err_o, exp_err);
    if (!exp_err) chk({name, "_data"}, rf_rd_data_o, exp_d);
    chk({name, "_ready"}, ex_ready_o, 1);
    tick;
  endtask

  initial begin
    int seen;
    tick; tick;
    chk("rst_we", rf_we_o, 0);
    chk("rst_retire", retire_o, 0);
    chk("rst_data", rf_rd_data_o, 0);
    chk("rst_ready", ex_ready_o, 1);
    rst = 0;
    ex_valid_i = 1; ex_rd_we_i = 1; ex_rd_addr_i = 5; ex_result_i = 32'h11;
    tick;
    chk("nl0_we", rf_we_o, 1); chk("nl0_addr", rf_rd_addr_o, 5); chk("nl0_data", rf_rd_data_o, 32'h11);
    ex_rd_addr_i = 6; ex_result_i = 32'h22;
    tick;
    chk("nl1_we", rf_we_o, 1); chk("nl1_addr", rf_rd_addr_o, 6); chk("nl1_ready", ex_ready_o, 1);
    ex_rd_addr_i = 0; ex_result_i = 32'h33;
    tick;
    chk("nl2_we", rf_we_o, 0); chk("nl2_retire", retire_o, 1); chk("nl2_data", rf_rd_data_o, 32'h33);
    ex_valid_i = 0;
    tick;
    chk("nl_idle_retire", retire_o, 0);
    do_load("lb", 3'b000, 2'd3, 32'h80FF_1234, 0, 4, 32'hFFFF_FF80, 1, 0);
    do_load("lbu", 3'b100, 2'd3, 32'h80FF_1234, 0, 1, 32'h0000_0080, 1, 0);
    do_load("lhu", 3'b101, 2'd2, 32'h80FF_1234, 0, 1, 32'h0000_80FF, 1, 0);
    do_load("lh", 3'b001, 2'd0, 32'h80FF_1234, 0, 1, 32'h0000_1234, 1, 0);
    do_load("lh2", 3'b001, 2'd2, 32'h80FF_1234, 0, 2, 32'hFFFF_80FF, 1, 0);
    do_load("lb1", 3'b000, 2'd1, 32'h80FF_1234, 0, 0, 32'h0000_0012, 1, 0);
    do_load("lw", 3'b010, 2'd0, 32'h80FF_1234, 0, 1, 32'h80FF_1234, 1, 0);
    do_load("f_lw2", 3'b010, 2'd2, 32'h80FF_1234, 0, 1, 0, 0, 1);
    do_load("f_lh1", 3'b001, 2'd1, 32'h80FF_1234, 0, 1, 0, 0, 1);
    do_load("f_011", 3'b011, 2'd0, 32'h80FF_1234, 0, 1, 0, 0, 1);
    do_load("f_bus", 3'b010, 2'd0, 32'h80FF_1234, 1, 1, 0, 0, 1);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
    tick;
    dmem_rvalid_i = 0;
    chk("idle_rvalid_retire", retire_o, 0);
    ex_valid_i = 1; ex_is_load_i = 1; ex_rd_we_i = 1; ex_rd_addr_i = 9; ex_funct3_i = 3'b010; ex_addr_lsb_i = 0;
    tick;
    ex_valid_i = 0; ex_is_load_i = 0;
    tick;
    rst = 1;
    tick;
    rst = 0; dmem_rvalid_i = 1;
    tick;
    dmem_rvalid_i = 0;
    chk("rstmid_retire", retire_o, 0);
    chk("rstmid_we", rf_we_o, 0);
    chk("rstmid_ready", ex_ready_o, 1);
    ex_valid_i = 1; ex_is_load_i = 1;
    tick;
    ex_valid_i = 0; ex_is_load_i = 0;
    seen = 0;
`ifdef WB_LOAD_TIMEOUT_EN
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      tick;
      if (retire_o) seen = i;
    end
    chk("to_cycle", seen, TO);
    chk("to_err", load_err_o, 1);
    chk("to_we", rf_we_o, 0);
    dmem_rvalid_i = 1;
    tick;
    dmem_rvalid_i = 0;
    chk("to_late_rvalid", retire_o, 0);
`else
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (retire_o) seen = i;
    end
    chk("noto_retire", seen, 0);
    chk("noto_ready", ex_ready_o, 0);
    dmem_rvalid_i = 1;
    tick;
    dmem_rvalid_i = 0;
    chk("noto_done", retire_o, 1);
`endif
    tick; tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
